// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the single register-file write port between NREQ
//            writeback requesters. One request is granted per cycle. The
//            granted write is registered onto we3/wa3/wd3. A per-register
//            busy scoreboard is set by decode reservations and cleared by
//            granted writes.
// Build    : WBARB_ROUND_ROBIN_EN defined   -> round-robin arbitration
//            WBARB_ROUND_ROBIN_EN undefined -> fixed priority (lowest wins)
// Ports    : clk, rst_n (async, active low)
//            req_valid/req_rd/req_data  - packed per-requester write requests
//            req_ready                  - one-hot grant (combinational)
//            rsv_valid/rsv_rd           - destination reservation from decode
//            we3/wa3/wd3/grant_id       - registered write port + owner
//            busy                       - scoreboard, busy[0] always 0
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int NREQ = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [5*NREQ-1:0]  req_rd,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               rsv_valid,
  input  logic [4:0]         rsv_rd,
  output logic               we3,
  output logic [4:0]         wa3,
  output logic [31:0]        wd3,
  output logic [31:0]        busy,
  output logic [2:0]         grant_id
);

  logic        r_we3;
  logic [4:0]  r_wa3;
  logic [31:0] r_wd3;
  logic [31:0] r_busy;
  logic [2:0]  r_grant_id;

  logic        w_gnt_any;
  logic [2:0]  w_gnt_idx;
  logic [4:0]  w_gnt_rd;
  logic [31:0] w_gnt_data;
  logic [31:0] w_busy_nxt;

`ifdef WBARB_ROUND_ROBIN_EN
  localparam logic [2:0] c_last_rst = 3'(NREQ - 1);

  logic [2:0] r_last;
  int         w_dist;
  int         w_best;
`endif

  // Grant selection. In round-robin mode each requester gets a distance
  // from last+1 (mod NREQ); the valid requester with the smallest distance
  // wins. This keeps every index constant and avoids a variable rotate.
  always_comb begin
    w_gnt_any  = 1'b0;
    w_gnt_idx  = '0;
    w_gnt_rd   = '0;
    w_gnt_data = '0;
`ifdef WBARB_ROUND_ROBIN_EN
    w_best = NREQ;
    w_dist = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i + NREQ - 1 - int'(r_last)) % NREQ;
      if (req_valid[i] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_gnt_any  = 1'b1;
        w_gnt_idx  = 3'(i);
        w_gnt_rd   = req_rd[5*i +: 5];
        w_gnt_data = req_data[32*i +: 32];
      end
    end
`else
    // Scan downward so the lowest valid index is the last one written.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_gnt_any  = 1'b1;
        w_gnt_idx  = 3'(i);
        w_gnt_rd   = req_rd[5*i +: 5];
        w_gnt_data = req_data[32*i +: 32];
      end
    end
`endif
    // No grant may be consumed while the block is held in reset.
    if (!rst_n) begin
      w_gnt_any = 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = w_gnt_any && (w_gnt_idx == 3'(gi));
    end
  endgenerate

  // Scoreboard next state: the reservation is applied after the clear so a
  // same-register collision leaves the bit set for the newer producer.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_gnt_any) begin
      w_busy_nxt[w_gnt_rd] = 1'b0;
    end
    if (rsv_valid && (rsv_rd != 5'd0)) begin
      w_busy_nxt[rsv_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we3      <= 1'b0;
      r_wa3      <= '0;
      r_wd3      <= '0;
      r_grant_id <= '0;
      r_busy     <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_we3  <= w_gnt_any && (w_gnt_rd != 5'd0);
      if (w_gnt_any) begin
        // Address/data/owner follow every grant, including x0 writes.
        r_wa3      <= w_gnt_rd;
        r_wd3      <= w_gnt_data;
        r_grant_id <= w_gnt_idx;
      end
    end
  end

`ifdef WBARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= c_last_rst;
    end else if (w_gnt_any) begin
      r_last <= w_gnt_idx;
    end
  end
`endif

  assign we3      = r_we3;
  assign wa3      = r_wa3;
  assign wd3      = r_wd3;
  assign busy     = r_busy;
  assign grant_id = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Self-checking bench for regfile_wb_arbiter (NREQ = 3). A
//            behavioural model holds the expected write port, scoreboard and
//            arbitration pointer; directed scenarios are followed by a
//            randomized traffic phase.
// Build    : follows WBARB_ROUND_ROBIN_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [5*NREQ-1:0]  req_rd;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rsv_valid;
  logic [4:0]         rsv_rd;
  logic               we3;
  logic [4:0]         wa3;
  logic [31:0]        wd3;
  logic [31:0]        busy;
  logic [2:0]         grant_id;

  regfile_wb_arbiter #(.NREQ(NREQ)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsv_valid (rsv_valid),
    .rsv_rd    (rsv_rd),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Requester side: a pending request is held until it is granted.
  logic        pend [NREQ];
  logic [4:0]  prd  [NREQ];
  logic [31:0] pdat [NREQ];

  // Model state.
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [2:0]  m_gid;
  logic [31:0] m_busy;
  int          m_last;

  int          g_last;
  logic [NREQ-1:0] ready_cap;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_we = 0; m_wa = 0; m_wd = 0; m_gid = 0; m_busy = 0; m_last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 0; prd[i] = 0; pdat[i] = 0;
    end
  endtask

  // Expected winner among pending requesters, -1 when nobody asks.
  function automatic int exp_grant();
`ifdef WBARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (m_last + k) % NREQ;
      if (pend[j]) return j;
    end
`else
    for (int j = 0; j < NREQ; j++) if (pend[j]) return j;
`endif
    return -1;
  endfunction

  task automatic drive(input logic rv, input logic [4:0] rr);
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = pend[i];
      req_rd[5*i +: 5]      = prd[i];
      req_data[32*i +: 32]  = pdat[i];
    end
    rsv_valid = rv;
    rsv_rd    = rr;
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic step(input logic rv, input logic [4:0] rr);
    int g;
    logic [NREQ-1:0] exp_ready;
    drive(rv, rr);
    @(negedge clk);
    g = exp_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    ready_cap = req_ready;
    chk("req_ready", req_ready, exp_ready);
    chk("we3", we3, m_we);
    chk("wa3", wa3, m_wa);
    chk("wd3", wd3, m_wd);
    chk("grant_id", grant_id, m_gid);
    chk("busy", busy, m_busy);
    @(posedge clk);
    g_last = g;
    if (g >= 0) begin
      m_we  = (prd[g] != 0);
      m_wa  = prd[g];
      m_wd  = pdat[g];
      m_gid = 3'(g);
      m_busy[prd[g]] = 1'b0;
      m_last = g;
      pend[g] = 0;
    end else begin
      m_we = 0;
    end
    if (rv && rr != 0) m_busy[rr] = 1'b1;
    m_busy[0] = 1'b0;
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] d);
    pend[i] = 1; prd[i] = rd; pdat[i] = d;
  endtask

  int exp_order [6];

  initial begin
`ifdef WBARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 2, 0, 1, 2};
`else
    exp_order = '{0, 0, 0, 0, 0, 0};
`endif
    rst_n = 0;
    model_reset();
    drive(1'b0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we3", we3, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    rst_n = 1;

    // Reset in the middle of traffic with busy = 0x6.
    step(1'b1, 5'd1);
    step(1'b1, 5'd2);
    chk("pre_rst_busy", busy, 32'h6);
    set_req(1, 5'd9, 32'h1111_2222);
    set_req(2, 5'd10, 32'h3333_4444);
    step(1'b0, 5'd0);                    // one grant lands on the write port
    drive(1'b0, 5'd0);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_we3", we3, 0);
    chk("mid_rst_wa3", wa3, 0);
    chk("mid_rst_wd3", wd3, 0);
    chk("mid_rst_gid", grant_id, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    model_reset();
    drive(1'b0, 5'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk);
    #1;

    // Fairness: everyone valid for six cycles, first grant after reset.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i]) set_req(i, 5'(11 + i), 32'hA000_0000 + 32'(c * 4 + i));
      step(1'b0, 5'd0);
      chk("fair_order", 64'(g_last), 64'(exp_order[c]));
    end
    model_reset_requests();
    step(1'b0, 5'd0);                    // drain so only directed traffic follows

    // Single write to a reserved register.
    step(1'b1, 5'd5);
    set_req(1, 5'd5, 32'hDEAD_BEEF);
    step(1'b0, 5'd0);
    chk("sw_ready", ready_cap, 3'b010);
    chk("sw_we3", we3, 1);
    chk("sw_wa3", wa3, 5);
    chk("sw_wd3", wd3, 32'hDEAD_BEEF);
    chk("sw_gid", grant_id, 1);
    chk("sw_busy5", busy[5], 0);

    // x0 write and x0 reservation.
    set_req(2, 5'd0, 32'h0BAD_F00D);
    step(1'b1, 5'd0);
    chk("x0_ready", ready_cap, 3'b100);
    chk("x0_we3", we3, 0);
    chk("x0_gid", grant_id, 2);
    chk("x0_busy", busy, m_busy);

    // Same-cycle reservation and grant to x7.
    step(1'b1, 5'd7);
    set_req(0, 5'd7, 32'h7777_7777);
    step(1'b1, 5'd7);
    chk("col_busy7", busy[7], 1);
    chk("col_we3", we3, 1);
    chk("col_wa3", wa3, 7);

    // Back-to-back writes from requester 0.
    set_req(0, 5'd3, 32'h3);
    step(1'b0, 5'd0);
    chk("b2b_we3_a", we3, 1);
    chk("b2b_wa3_a", wa3, 3);
    set_req(0, 5'd4, 32'h4);
    step(1'b0, 5'd0);
    chk("b2b_we3_b", we3, 1);
    chk("b2b_wa3_b", wa3, 4);
    step(1'b0, 5'd0);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      logic rv;
      logic [4:0] rr;
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && ($urandom_range(0, 99) < 55))
          set_req(i, 5'($urandom_range(0, 31)), $urandom);
      rv = ($urandom_range(0, 99) < 40);
      rr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) rr = prd[$urandom_range(0, NREQ - 1)];
      step(rv, rr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  task automatic model_reset_requests();
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
  endtask

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single register-file write port (`we3`/`wa3`/`wd3`) between `NREQ` writeback requesters, such as the ALU, load unit and multiply/divide unit. It grants one request per cycle, round-robin, and drives a registered write to the register file. It also keeps a per-register busy scoreboard, set when decode reserves a destination and cleared when the write is granted. The hazard logic reads this scoreboard to stall operand reads.

## Interface
Parameters:
- `NREQ`, default 3: number of writeback requesters, 2..8.

Ports:
- `clk` input 1: clock. All state is updated on the rising edge. The register file samples the write-port outputs on the falling edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input NREQ: requester i has a pending write.
- `req_rd` input 5*NREQ: destination register of requester i, in bits [5i+4:5i].
- `req_data` input 32*NREQ: write data of requester i, in bits [32i+31:32i].
- `req_ready` output NREQ: one-hot grant. The request is consumed in this cycle. Combinational from `req_valid`.
- `rsv_valid` input 1: decode reserves destination `rsv_rd` this cycle.
- `rsv_rd` input 5: reserved destination register.
- `we3` output 1: register-file write enable. Registered.
- `wa3` output 5: register-file write address. Registered.
- `wd3` output 32: register-file write data. Registered.
- `busy` output 32: scoreboard, one bit per register. A set bit means a write to that register is outstanding. `busy[0]` is tied to 0.
- `grant_id` output 3: index of the requester that owns the current `we3` write. Registered.

## Operation
- **Arbitration.** Each cycle, at most one `req_ready` bit is set.
  - The search starts at `last+1` modulo `NREQ`, where `last` is the last granted index.
  - `last` updates only on a grant.
  - A requester holds `req_valid`, `req_rd` and `req_data` stable until it sees `req_ready`.
- **Write register.** The output register is always able to accept a write, so a grant is never blocked.
  - On a grant with rd≠0: next-cycle `we3`=1, `wa3`=rd, `wd3`=data, `grant_id`=i.
  - On a grant with rd=0: the grant is consumed but `we3`=0. `wa3`, `wd3` and `grant_id` still update.
  - With no grant: `we3`=0 and `wa3`, `wd3`, `grant_id` hold their values.
- **Scoreboard.**
  - `busy[rsv_rd]` is set on `rsv_valid` when rsv_rd≠0.
  - `busy[rd]` is cleared on a grant.
  - A reservation for x0 is ignored.
- **Simultaneous set and clear.** If a reservation and a grant hit the same rd in the same cycle, the reservation wins and the bit stays set, because a newer producer now owns the register. Different registers are updated independently.
- **Unreserved write.** A grant to a register whose busy bit is clear is legal; the bit stays 0.
- **Reset mid-operation.** All outstanding requests are discarded and the scoreboard is cleared. Requesters must re-present after reset.

## Timing
- **Reset values.** `we3`=0, `wa3`=0, `wd3`=0, `grant_id`=0, `busy`=0, `last`=NREQ-1 (so requester 0 is searched first). `req_ready`=0 while `rst_n`=0.
- **Latency.**
  - Request valid in cycle N: `req_ready` is high in cycle N.
  - `we3`/`wa3`/`wd3` are valid during cycle N+1, and the register file writes at the falling edge inside N+1.
  - The busy bit reads 0 from cycle N+1 onward.
- **Throughput.** One write per cycle. With all requesters continuously valid, each one is granted once every `NREQ` cycles (no starvation).
- **Reservation.** `rsv_valid` in cycle N makes `busy` visible as 1 from cycle N+1.
- `req_ready` has no combinational path from `rsv_*`.

## Configuration
- **`WBARB_ROUND_ROBIN_EN` defined:** round-robin arbitration as described in Operation.
- **`WBARB_ROUND_ROBIN_EN` undefined:** fixed priority, where the lowest index wins. `last` is not implemented, and requester 0 can starve the others.
- All other behaviour is identical in both builds.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-stream with `busy`=0x0000_0006 → all outputs go to 0 immediately, `busy`=0. After release, requester 0 is granted first.
- **Single write.**
  - Stimulus: requester 1 valid with rd=5, data=0xDEADBEEF in cycle N; `busy[5]`=1 beforehand.
  - Response: `req_ready`=3'b010 in N. In N+1, `we3`=1, `wa3`=5, `wd3`=0xDEADBEEF, `grant_id`=1. `busy[5]`=0 in N+1.
- **Fairness.** All 3 requesters held valid for 6 cycles (round-robin build) → grant order 0,1,2,0,1,2.
  - Fixed-priority build: requester 0 granted 6 times.
- **x0 write.** Requester 2 with rd=0 → granted, `we3`=0 next cycle, `busy[0]`=0. A reservation of rd=0 leaves `busy` unchanged.
- **Set/clear collision.** `rsv_valid` with rd=7 and a grant with rd=7 in the same cycle → `busy[7]`=1 next cycle, and `we3`=1 with `wa3`=7.
- **Back-to-back.** Requester 0 writes rd=3 then rd=4 in consecutive cycles → `wa3`=3 then 4 on consecutive cycles, with `we3` high both cycles.
